param_return_stack: RTL and testbench

PARAM_RETURN_STACK -- requirements
Module: param_return_stack

---
 rtl/rstack_pkg.sv | 15 +
 rtl/param_return_stack_if.sv | 27 ++
 rtl/rstack_ram.sv | 29 ++
 rtl/param_return_stack.sv | 125 ++++++++++++
 tb/tb_param_return_stack.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/rstack_pkg.sv
// Shared definitions for the parameterised return stack: operation encoding
// and default geometry.
package rstack_pkg;

    typedef enum logic [1:0] {
        RS_NOP  = 2'd0,
        RS_PUSH = 2'd1,
        RS_REPL = 2'd2,
        RS_POP  = 2'd3
    } rs_op_t;

    localparam int RS_WIDTH = 16;
    localparam int RS_DEPTH = 64;

endpackage

// File: rtl/param_return_stack_if.sv
// Operation/data bundle of the return stack. The master side issues
// operations and the slave side (the stack) reports its top entries and status.
interface param_return_stack_if import rstack_pkg::*; #(
    parameter int WIDTH = RS_WIDTH,
    parameter int DEPTH = RS_DEPTH
) ();
    logic [1:0]             stackOP;
    logic [WIDTH-1:0]       w;
    logic                   clr_err;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic [$clog2(DEPTH):0] count;
    logic                   empty;
    logic                   full;
    logic                   ovf;
    logic                   unf;

    modport master (
        output stackOP, w, clr_err,
        input  a, b, count, empty, full, ovf, unf
    );

    modport slave (
        input  stackOP, w, clr_err,
        output a, b, count, empty, full, ovf, unf
    );
endinterface

// File: rtl/rstack_ram.sv
// DEPTH x WIDTH register array for the return stack: one synchronous write
// port and two asynchronous read ports (top and the entry below it).
// Contents are deliberately not reset; the controller gates stale data.
module rstack_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_top,
    input  logic [AW-1:0]    raddr_next,
    output logic [WIDTH-1:0] rdata_top,
    output logic [WIDTH-1:0] rdata_next
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Single write port, updated on the rising edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_top  = mem[raddr_top];
    assign rdata_next = mem[raddr_next];
endmodule

// File: rtl/param_return_stack.sv
// Parameterised return stack built as a circular buffer with a top pointer.
// PUSH at full overwrites the oldest entry. Optional sticky overflow/underflow
// flags are built only when RSTACK_ERR_FLAGS_EN is defined; otherwise ovf/unf
// read 0 and clr_err is ignored.
module param_return_stack import rstack_pkg::*; #(
    parameter int WIDTH = RS_WIDTH,
    parameter int DEPTH = RS_DEPTH
) (
    input  logic                 CLK,
    input  logic                 reset,
    param_return_stack_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    rs_op_t           op;
    logic [PW-1:0]    ptr_q;
    logic [PW-1:0]    ptr_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             we;
    logic [PW-1:0]    waddr;
    logic [WIDTH-1:0] top_data;
    logic [WIDTH-1:0] next_data;
    logic             is_empty;
    logic             is_full;

    assign op       = rs_op_t'(bus.stackOP);
    assign is_empty = (cnt_q == '0);
    assign is_full  = (cnt_q == FULL_CNT);

    // Next pointer, count and write request for the sampled operation.
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        we    = 1'b0;
        waddr = ptr_q;
        unique case (op)
            RS_PUSH: begin
                ptr_d = ptr_q + PW'(1);
                waddr = ptr_q + PW'(1);
                we    = 1'b1;
                if (!is_full) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RS_REPL: begin
                we = 1'b1;
                if (is_empty) begin
                    ptr_d = ptr_q + PW'(1);
                    waddr = ptr_q + PW'(1);
                    cnt_d = CW'(1);
                end
            end
            RS_POP: begin
                if (!is_empty) begin
                    ptr_d = ptr_q - PW'(1);
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: ;
        endcase
    end

    // Pointer and count registers; reset discards every entry at once.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    rstack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk        (CLK),
        .we         (we),
        .waddr      (waddr),
        .wdata      (bus.w),
        .raddr_top  (ptr_q),
        .raddr_next (ptr_q - PW'(1)),
        .rdata_top  (top_data),
        .rdata_next (next_data)
    );

    assign bus.a     = is_empty ? '0 : top_data;
    assign bus.b     = (cnt_q < CW'(2)) ? '0 : next_data;
    assign bus.count = cnt_q;
    assign bus.empty = is_empty;
    assign bus.full  = is_full;

`ifdef RSTACK_ERR_FLAGS_EN
    logic ovf_q;
    logic unf_q;
    logic ovf_set;
    logic unf_set;

    assign ovf_set = (op == RS_PUSH) && is_full;
    assign unf_set = (op == RS_POP) && is_empty;

    // Sticky error flags; an error in the clearing cycle leaves the flag set.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= (ovf_q & ~bus.clr_err) | ovf_set;
            unf_q <= (unf_q & ~bus.clr_err) | unf_set;
        end
    end

    assign bus.ovf = ovf_q;
    assign bus.unf = unf_q;
`else
    logic unused_clr_err;
    assign unused_clr_err = bus.clr_err;
    assign bus.ovf = 1'b0;
    assign bus.unf = 1'b0;
`endif
endmodule

// File: tb/tb_param_return_stack.sv
// Scoreboard testbench for param_return_stack. A queue-based reference stack
// predicts the visible state after each operation; a monitor on the falling
// edge pops the prediction and compares it with the DUT outputs.
// Flag expectations follow RSTACK_ERR_FLAGS_EN.
module tb_param_return_stack;
    import rstack_pkg::*;

    localparam int WIDTH = 16;
    localparam int DEPTH = 64;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef RSTACK_ERR_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [CW-1:0]    count;
        logic             empty;
        logic             full;
        logic             ovf;
        logic             unf;
        int               seq;
    } exp_t;

    logic CLK   = 1'b0;
    logic reset = 1'b1;

    param_return_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    param_return_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 CLK = ~CLK;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] model[$];
    bit               model_ovf = 1'b0;
    bit               model_unf = 1'b0;
    int               total_checks  = 0;
    int               passed_checks = 0;
    int               seq_no = 0;

    function automatic exp_t expectedNow();
        exp_t e;
        int n;
        n = model.size();
        e.a     = (n >= 1) ? model[n-1] : '0;
        e.b     = (n >= 2) ? model[n-2] : '0;
        e.count = CW'(n);
        e.empty = (n == 0);
        e.full  = (n == DEPTH);
        e.ovf   = model_ovf;
        e.unf   = model_unf;
        e.seq   = seq_no;
        return e;
    endfunction

    task automatic compareField(input string name, input int seq,
                                input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act === exp) begin
            passed_checks++;
        end else begin
            $display("[TB] FAIL %s (op #%0d): got %0h, expected %0h", name, seq, act, exp);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        compareField("a",     e.seq, 32'(bus.a),     32'(e.a));
        compareField("b",     e.seq, 32'(bus.b),     32'(e.b));
        compareField("count", e.seq, 32'(bus.count), 32'(e.count));
        compareField("empty", e.seq, 32'(bus.empty), 32'(e.empty));
        compareField("full",  e.seq, 32'(bus.full),  32'(e.full));
        compareField("ovf",   e.seq, 32'(bus.ovf),   32'(e.ovf));
        compareField("unf",   e.seq, 32'(bus.unf),   32'(e.unf));
    endtask

    // Drive one operation for the coming edge and queue the predicted state.
    task automatic applyStimulus(input rs_op_t op, input logic [WIDTH-1:0] data, input bit clr);
        bit ov;
        bit un;
        @(negedge CLK);
        #1;
        bus.stackOP = op;
        bus.w       = data;
        bus.clr_err = clr;
        ov = 1'b0;
        un = 1'b0;
        case (op)
            RS_PUSH: begin
                if (model.size() == DEPTH) begin
                    model.delete(0);
                    ov = 1'b1;
                end
                model.push_back(data);
            end
            RS_REPL: begin
                if (model.size() == 0) model.push_back(data);
                else model[model.size()-1] = data;
            end
            RS_POP: begin
                if (model.size() == 0) un = 1'b1;
                else model.delete(model.size()-1);
            end
            default: ;
        endcase
        if (FLAGS_EN) begin
            model_ovf = (model_ovf && !clr) || ov;
            model_unf = (model_unf && !clr) || un;
        end
        seq_no++;
        exp_q.push_back(expectedNow());
    endtask

    // Assert reset between edges, check it took effect immediately, release after a posedge.
    task automatic pulseReset();
        @(negedge CLK);
        #1;
        bus.stackOP = RS_NOP;
        bus.clr_err = 1'b0;
        reset = 1'b0;
        #1;
        model.delete();
        model_ovf = 1'b0;
        model_unf = 1'b0;
        seq_no++;
        checkOutput(expectedNow());
        repeat (2) @(posedge CLK);
        #2 reset = 1'b1;
    endtask

    // Monitor: compare each queued prediction one falling edge after its operation.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    // Directed scenarios followed by weighted random operations.
    initial begin
        bus.stackOP = RS_NOP;
        bus.w       = '0;
        bus.clr_err = 1'b0;
        #1 reset = 1'b0;
        #1 checkOutput(expectedNow());
        @(posedge CLK);
        #2 reset = 1'b1;

        applyStimulus(RS_PUSH, 16'd1, 1'b0);

        pulseReset();
        applyStimulus(RS_PUSH, 16'd2, 1'b0);
        applyStimulus(RS_PUSH, 16'd4, 1'b0);
        applyStimulus(RS_POP,  16'd0, 1'b0);
        applyStimulus(RS_POP,  16'd0, 1'b0);
        applyStimulus(RS_POP,  16'd0, 1'b0);

        pulseReset();
        for (int i = 1; i <= DEPTH; i++) applyStimulus(RS_PUSH, WIDTH'(i), 1'b0);
        for (int i = 0; i < DEPTH - 1; i++) applyStimulus(RS_POP, 16'd0, 1'b0);
        for (int i = 1; i <= DEPTH + 1; i++) applyStimulus(RS_PUSH, WIDTH'(i), 1'b0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(RS_POP, 16'd0, 1'b0);

        pulseReset();
        applyStimulus(RS_PUSH, 16'd7, 1'b0);
        applyStimulus(RS_REPL, 16'd9, 1'b0);
        applyStimulus(RS_POP,  16'd0, 1'b0);
        applyStimulus(RS_REPL, 16'd5, 1'b0);

        pulseReset();
        for (int i = 1; i <= DEPTH + 1; i++) applyStimulus(RS_PUSH, WIDTH'(i * 3), 1'b0);
        applyStimulus(RS_PUSH, 16'hBEEF, 1'b1);
        applyStimulus(RS_NOP,  16'd0,    1'b1);
        applyStimulus(RS_POP,  16'd0,    1'b0);

        pulseReset();
        for (int i = 0; i < 10; i++) applyStimulus(RS_PUSH, WIDTH'(100 + i), 1'b0);
        pulseReset();
        applyStimulus(RS_POP, 16'd0, 1'b0);
        applyStimulus(RS_NOP, 16'd0, 1'b1);

        for (int i = 0; i < 700; i++) begin
            int r;
            rs_op_t op;
            r = $urandom_range(0, 9);
            if (r <= 4)      op = RS_PUSH;
            else if (r == 5) op = RS_REPL;
            else if (r <= 8) op = RS_POP;
            else             op = RS_NOP;
            applyStimulus(op, WIDTH'($urandom), ($urandom_range(0, 9) == 0));
            if (i == 350) pulseReset();
        end

        repeat (2) @(negedge CLK);
        #1;
        total_checks++;
        if (exp_q.size() == 0) begin
            passed_checks++;
        end else begin
            $display("[TB] FAIL drain: got %0d pending predictions, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end
endmodule
